// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back, write-allocate cache controller with per-set round-robin victims.
// Registered outputs; a hit completes two cycles after acceptance, a miss writes back a dirty victim then fills.
module assoc_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 1024,
  parameter int WAYS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_valid,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_req_data,
  input  logic [DATA_W/8-1:0] cpu_req_be,
  input  logic                cpu_req_rw,
  output logic [DATA_W-1:0]   cpu_res_data,
  output logic                cpu_res_ready,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [LINE_W-1:0]   mem_req_data,
  output logic                mem_req_rw,
  input  logic [LINE_W-1:0]   mem_res_data,
  input  logic                mem_res_ready
);
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = ADDR_W - IDX - OFF;
  localparam int BYTES = DATA_W / 8;
  localparam int WPL   = LINE_W / DATA_W;
  localparam int BOFF  = $clog2(BYTES);
  localparam int WSW   = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int NW    = 1 << WW;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
  state_t state, state_nxt;

  // Way storage spans the whole WW-bit index range; slots at or above WAYS are never written.
  logic [SETS-1:0][NW-1:0] valid_q;
  logic [SETS-1:0][NW-1:0] dirty_q;
  logic [SETS-1:0][WW-1:0] rr_q;
  logic [TAG-1:0]          tag_q  [NW][SETS];
  logic [LINE_W-1:0]       data_q [NW][SETS];

  logic [TAG-1:0]    req_tag;
  logic [IDX-1:0]    req_idx;
  logic [WSW-1:0]    req_word;
  logic [DATA_W-1:0] req_data;
  logic [BYTES-1:0]  req_be;
  logic              req_rw;
  logic [WW-1:0]     victim_way;
  logic              victim_rr;

  logic              hit, inv_found, miss_dirty;
  logic [WW-1:0]     hit_way, inv_way, miss_way;
  logic [LINE_W-1:0] hit_line, merged_line;
  logic [DATA_W-1:0] hit_word;
  logic              accept, hit_wr, fill_done;
  logic              addr_lsb_unused;

  assign accept    = (state == IDLE) && cpu_req_valid && !cpu_res_ready;
  assign hit_wr    = !rst && (state == COMPARE) && hit && req_rw;
  assign fill_done = !rst && (state == ALLOCATE) && mem_res_ready;
  assign addr_lsb_unused = ^cpu_req_addr[0 +: ((BOFF > 0) ? BOFF : 1)];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    miss_way   = inv_found ? inv_way : rr_q[req_idx];
    miss_dirty = valid_q[req_idx][miss_way] && dirty_q[req_idx][miss_way];
  end

  always_comb begin
    hit_line    = data_q[hit_way][req_idx];
    hit_word    = hit_line[req_word*DATA_W +: DATA_W];
    merged_line = hit_line;
    for (int b = 0; b < BYTES; b++)
      if (req_be[b]) merged_line[req_word*DATA_W + b*8 +: 8] = req_data[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept) state_nxt = COMPARE;
      COMPARE:    state_nxt = hit ? IDLE : (miss_dirty ? WRITE_BACK : ALLOCATE);
      WRITE_BACK: if (mem_res_ready) state_nxt = ALLOCATE;
      ALLOCATE:   if (mem_res_ready) state_nxt = COMPARE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_res_ready <= 1'b0;
      cpu_res_data  <= '0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      victim_way    <= '0;
      victim_rr     <= 1'b0;
      valid_q       <= '0;
      dirty_q       <= '0;
      rr_q          <= '0;
    end else begin
      cpu_res_ready <= 1'b0;
      case (state)
        COMPARE: begin
          if (hit) begin
            cpu_res_ready <= 1'b1;
            if (req_rw) dirty_q[req_idx][hit_way] <= 1'b1;
            else        cpu_res_data <= hit_word;
          end else begin
            victim_way    <= miss_way;
            victim_rr     <= !inv_found;
            mem_req_valid <= 1'b1;
            mem_req_rw    <= miss_dirty;
            mem_req_addr  <= miss_dirty ? {tag_q[miss_way][req_idx], req_idx, {OFF{1'b0}}}
                                        : {req_tag, req_idx, {OFF{1'b0}}};
            if (miss_dirty) mem_req_data <= data_q[miss_way][req_idx];
          end
        end
        // Valid stays high into the fill so rw flips 1->0 with no gap.
        WRITE_BACK: if (mem_res_ready) begin
          mem_req_rw   <= 1'b0;
          mem_req_addr <= {req_tag, req_idx, {OFF{1'b0}}};
        end
        ALLOCATE: if (mem_res_ready) begin
          mem_req_valid                  <= 1'b0;
          valid_q[req_idx][victim_way]   <= 1'b1;
          dirty_q[req_idx][victim_way]   <= 1'b0;
          if (victim_rr && (WAYS > 1)) rr_q[req_idx] <= rr_q[req_idx] + WW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_tag  <= cpu_req_addr[ADDR_W-1 -: TAG];
      req_idx  <= cpu_req_addr[OFF +: IDX];
      req_word <= (WPL > 1) ? cpu_req_addr[BOFF +: WSW] : '0;
      req_data <= cpu_req_data;
      req_be   <= cpu_req_be;
      req_rw   <= cpu_req_rw;
    end
    if (hit_wr) data_q[hit_way][req_idx] <= merged_line;
    if (fill_done) begin
      data_q[victim_way][req_idx] <= mem_res_data;
      tag_q[victim_way][req_idx]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Bench for assoc_cache_ctrl: 2-way default build with a line memory model and read-data scoreboard,
// plus a direct-mapped (WAYS=1) instance.
`timescale 1ns/1ps
module tb_assoc_cache_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         cpu_req_valid, cpu_req_rw, cpu_res_ready;
  logic [31:0]  cpu_req_addr, cpu_req_data, cpu_res_data;
  logic [3:0]   cpu_req_be;
  logic         mem_req_valid, mem_req_rw, mem_res_ready;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data, mem_res_data;

  logic         d1_req_valid, d1_req_rw, d1_res_ready;
  logic [31:0]  d1_req_addr, d1_req_data, d1_res_data;
  logic [3:0]   d1_req_be;
  logic         d1_mem_req_valid, d1_mem_req_rw, d1_mem_res_ready;
  logic [31:0]  d1_mem_req_addr;
  logic [127:0] d1_mem_req_data, d1_mem_res_data;

  assoc_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_be(cpu_req_be), .cpu_req_rw(cpu_req_rw),
    .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_rw(mem_req_rw), .mem_res_data(mem_res_data), .mem_res_ready(mem_res_ready)
  );

  assoc_cache_ctrl #(.WAYS(1)) dut_dm (
    .clk(clk), .rst(rst),
    .cpu_req_valid(d1_req_valid), .cpu_req_addr(d1_req_addr), .cpu_req_data(d1_req_data),
    .cpu_req_be(d1_req_be), .cpu_req_rw(d1_req_rw),
    .cpu_res_data(d1_res_data), .cpu_res_ready(d1_res_ready),
    .mem_req_valid(d1_mem_req_valid), .mem_req_addr(d1_mem_req_addr), .mem_req_data(d1_mem_req_data),
    .mem_req_rw(d1_mem_req_rw), .mem_res_data(d1_mem_res_data), .mem_res_ready(d1_mem_res_ready)
  );

  typedef struct { logic rw; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; logic rw; logic [127:0] data; } mtx_t;

  exp_t         exp_q[$];
  mtx_t         mem_log[$];
  logic [127:0] mem_img [logic [31:0]];
  int checks = 0, errors = 0;
  int mem_delay = 0, mem_valid_cycles = 0, unstable = 0;
  int d1_fills = 0, d1_wbs = 0;

  function automatic logic [127:0] line_pat(input logic [31:0] a);
    return {a ^ 32'h3333_0003, a ^ 32'h2222_0002, a ^ 32'h1111_0001, ~a};
  endfunction

  // Backing memory for the 2-way instance: answers after mem_delay waiting cycles.
  initial begin : mem_resp
    int wait_cnt;
    logic [31:0] hold_addr;
    logic hold_rw;
    mtx_t t;
    wait_cnt = 0; hold_addr = '0; hold_rw = 1'b0;
    mem_res_ready = 1'b0; mem_res_data = '0;
    forever begin
      @(negedge clk);
      mem_res_ready = 1'b0;
      if (mem_req_valid === 1'b1) begin
        mem_valid_cycles++;
        if (wait_cnt == 0) begin hold_addr = mem_req_addr; hold_rw = mem_req_rw; end
        else if (mem_req_addr !== hold_addr || mem_req_rw !== hold_rw) unstable++;
        if (wait_cnt >= mem_delay) begin
          t.addr = mem_req_addr; t.rw = mem_req_rw; t.data = mem_req_data;
          mem_log.push_back(t);
          if (mem_req_rw) mem_img[mem_req_addr] = mem_req_data;
          else mem_res_data = mem_img.exists(mem_req_addr) ? mem_img[mem_req_addr] : line_pat(mem_req_addr);
          mem_res_ready = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  initial begin : mem_resp_dm
    d1_mem_res_ready = 1'b0; d1_mem_res_data = '0;
    forever begin
      @(negedge clk);
      d1_mem_res_ready = 1'b0;
      if (d1_mem_req_valid === 1'b1) begin
        if (d1_mem_req_rw) d1_wbs++; else d1_fills++;
        d1_mem_res_data  = line_pat(d1_mem_req_addr);
        d1_mem_res_ready = 1'b1;
      end
    end
  end

  // Scoreboard consumer: every completion pops one expectation; reads compare data.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_res_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_ready: cpu_res_ready=1 with no outstanding request");
        end else begin
          e = exp_q.pop_front();
          if (!e.rw && cpu_res_data !== e.data) begin
            errors++; $display("FAIL read_data: got %h expected %h", cpu_res_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cpu_access(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic [31:0] exp_data, output int lat);
    exp_t e;
    e.rw = rw; e.data = exp_data;
    exp_q.push_back(e);
    cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_data = data; cpu_req_be = be;
    lat = 0;
    do begin @(negedge clk); lat++; end while (cpu_res_ready !== 1'b1 && lat < 200);
    if (cpu_res_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL timeout: addr %h no cpu_res_ready after %0d cycles", addr, lat);
      exp_q.delete();
    end
  endtask

  task automatic cpu_idle();
    cpu_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (cpu_res_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", cpu_res_ready); end
    if (cpu_res_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", cpu_res_data); end
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid: got %b expected 0", mem_req_valid); end
    if (mem_req_rw !== 1'b0) begin errors++; $display("FAIL rst_mrw: got %b expected 0", mem_req_rw); end
    if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_maddr: got %h expected 0", mem_req_addr); end
    if (mem_req_data !== 128'h0) begin errors++; $display("FAIL rst_mdata: got %h expected 0", mem_req_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    int lat;
    mem_img[32'h1000] = {32'h0403_0201, 32'h0807_0605, 32'hAABB_CCDD, 32'hDEAD_BEEF};
    mem_log.delete();
    cpu_access(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, lat);
    cpu_idle();
    checks += 2;
    if (lat !== 4) begin errors++; $display("FAIL miss_latency: got %0d expected 4", lat); end
    if (mem_log.size() !== 1) begin errors++; $display("FAIL miss_mem_count: got %0d expected 1", mem_log.size()); end
    else begin
      checks += 2;
      if (mem_log[0].addr !== 32'h1000) begin errors++; $display("FAIL miss_mem_addr: got %h expected 00001000", mem_log[0].addr); end
      if (mem_log[0].rw !== 1'b0) begin errors++; $display("FAIL miss_mem_rw: got %b expected 0", mem_log[0].rw); end
    end
  endtask

  task automatic test_read_hit();
    int lat, vc;
    vc = mem_valid_cycles;
    cpu_access(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, lat);
    cpu_idle();
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", lat); end
    cpu_access(1'b0, 32'h1004, 32'h0, 4'h0, 32'hAABB_CCDD, lat);
    cpu_idle();
    checks += 2;
    if (lat !== 2) begin errors++; $display("FAIL hit_latency_w1: got %0d expected 2", lat); end
    if (mem_valid_cycles !== vc) begin errors++; $display("FAIL hit_no_mem: got %0d mem cycles expected 0", mem_valid_cycles - vc); end
  endtask

  task automatic test_partial_write();
    int lat;
    cpu_access(1'b1, 32'h1004, 32'h1234_5678, 4'b0011, 32'h0, lat);
    cpu_idle();
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wr_hit_latency: got %0d expected 2", lat); end
    cpu_access(1'b0, 32'h1004, 32'h0, 4'h0, 32'hAABB_5678, lat);
    cpu_idle();
  endtask

  task automatic test_eviction();
    int lat;
    logic [127:0] l4, l8, merged;
    l4 = line_pat(32'h4000);
    l8 = line_pat(32'h8000);
    merged = line_pat(32'h0);
    merged[31:0] = 32'hCAFE_F00D;
    cpu_access(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, lat);
    cpu_idle();
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL wr_miss_latency: got %0d expected 4", lat); end
    cpu_access(1'b0, 32'h4000, 32'h0, 4'h0, l4[31:0], lat);
    cpu_idle();
    mem_log.delete();
    cpu_access(1'b0, 32'h8000, 32'h0, 4'h0, l8[31:0], lat);
    cpu_idle();
    checks += 2;
    if (lat !== 5) begin errors++; $display("FAIL dirty_miss_latency: got %0d expected 5", lat); end
    if (mem_log.size() !== 2) begin errors++; $display("FAIL evict_mem_count: got %0d expected 2", mem_log.size()); end
    else begin
      checks += 5;
      if (mem_log[0].rw !== 1'b1) begin errors++; $display("FAIL wb_rw: got %b expected 1", mem_log[0].rw); end
      if (mem_log[0].addr !== 32'h0) begin errors++; $display("FAIL wb_addr: got %h expected 00000000", mem_log[0].addr); end
      if (mem_log[0].data !== merged) begin errors++; $display("FAIL wb_data: got %h expected %h", mem_log[0].data, merged); end
      if (mem_log[1].rw !== 1'b0) begin errors++; $display("FAIL evict_fill_rw: got %b expected 0", mem_log[1].rw); end
      if (mem_log[1].addr !== 32'h8000) begin errors++; $display("FAIL evict_fill_addr: got %h expected 00008000", mem_log[1].addr); end
    end
    cpu_access(1'b0, 32'h4000, 32'h0, 4'h0, l4[31:0], lat);
    cpu_idle();
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL survivor_hit_latency: got %0d expected 2", lat); end
    // Round-robin now points at the way holding 0x4000 (clean): plain refill of 0x0 from written-back data.
    mem_log.delete();
    cpu_access(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, lat);
    cpu_idle();
    checks += 2;
    if (lat !== 4) begin errors++; $display("FAIL rr_refill_latency: got %0d expected 4", lat); end
    if (mem_log.size() !== 1) begin errors++; $display("FAIL rr_refill_count: got %0d expected 1", mem_log.size()); end
  endtask

  task automatic test_stall();
    int lat, vc;
    logic [127:0] l;
    l = line_pat(32'h2000);
    mem_delay = 20; unstable = 0; vc = mem_valid_cycles;
    cpu_access(1'b0, 32'h2000, 32'h0, 4'h0, l[31:0], lat);
    cpu_idle();
    mem_delay = 0;
    checks += 3;
    if (lat !== 24) begin errors++; $display("FAIL stall_latency: got %0d expected 24", lat); end
    if (unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
    if (mem_valid_cycles - vc !== 21) begin errors++; $display("FAIL stall_valid_cycles: got %0d expected 21", mem_valid_cycles - vc); end
  endtask

  task automatic test_reset_mid();
    int n, lat;
    mem_delay = 1000;
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h3000;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks += 2;
    if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rm_fill_start: got %b expected 1", mem_req_valid); end
    if (mem_req_rw !== 1'b0) begin errors++; $display("FAIL rm_fill_rw: got %b expected 0", mem_req_rw); end
    repeat (3) @(negedge clk);
    rst = 1'b1; cpu_req_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_drop: got %b expected 0", mem_req_valid); end
    if (cpu_res_ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b expected 0", cpu_res_ready); end
    rst = 1'b0; mem_delay = 0;
    @(negedge clk);
    mem_log.delete();
    cpu_access(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, lat);
    cpu_idle();
    checks += 2;
    if (lat !== 4) begin errors++; $display("FAIL rm_remiss_latency: got %0d expected 4", lat); end
    if (mem_log.size() !== 1) begin errors++; $display("FAIL rm_remiss_count: got %0d expected 1", mem_log.size()); end
  endtask

  task automatic test_back_to_back();
    int lat;
    cpu_access(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL b2b_first: got %0d expected 2", lat); end
    // Held valid in the ready cycle is not accepted until the following edge.
    cpu_access(1'b0, 32'h1004, 32'h0, 4'h0, 32'hAABB_CCDD, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL b2b_read: got %0d expected 3", lat); end
    cpu_access(1'b1, 32'h1008, 32'h0000_0055, 4'hF, 32'h0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL b2b_write: got %0d expected 3", lat); end
    cpu_access(1'b0, 32'h1008, 32'h0, 4'h0, 32'h0000_0055, lat);
    cpu_idle();
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL b2b_readback: got %0d expected 3", lat); end
  endtask

  task automatic test_direct_mapped();
    logic [31:0] a;
    logic [127:0] l;
    int lat;
    d1_fills = 0; d1_wbs = 0;
    for (int i = 0; i < 8; i++) begin
      a = i[0] ? 32'h4000 : 32'h0;
      l = line_pat(a);
      d1_req_valid = 1'b1; d1_req_addr = a; d1_req_rw = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (d1_res_ready !== 1'b1 && lat < 50);
      checks += 2;
      if (lat !== 4) begin errors++; $display("FAIL dm_latency[%0d]: got %0d expected 4", i, lat); end
      if (d1_res_data !== l[31:0]) begin errors++; $display("FAIL dm_data[%0d]: got %h expected %h", i, d1_res_data, l[31:0]); end
      d1_req_valid = 1'b0;
      @(negedge clk);
    end
    checks += 2;
    if (d1_fills !== 8) begin errors++; $display("FAIL dm_fills: got %0d expected 8", d1_fills); end
    if (d1_wbs !== 0) begin errors++; $display("FAIL dm_writebacks: got %0d expected 0", d1_wbs); end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_be = '0;
    d1_req_valid = 1'b0; d1_req_rw = 1'b0; d1_req_addr = '0; d1_req_data = '0; d1_req_be = '0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_partial_write();
    test_eviction();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_direct_mapped();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
